wakeup_arbiter: RTL and testbench
=================================

WAKEUP_ARBITER -- requirements
Module: wakeup_arbiter

Interface
REQ-001 Parameters SHALL be: N_SRC, default 4, number of wake-up sources; TIMEOUT, default 30000, service window in clki cycles (300 us at 100 MHz); CNT_W, default 20, event counter width.
REQ-002 clki  in  1  single system clock, 100 MHz, all logic on posedge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 wake_up  in  N_SRC  asynchronous wake-up request lines, one per source.
REQ-005 WU_serviced  in  1  service engine done/abort for the current grant, level-sampled.
REQ-006 WU_valid  out  1  a grant is active and awaiting service.
REQ-007 grant_id  out  clog2(N_SRC)  index of the granted source, valid while WU_valid=1.
REQ-008 pending  out  N_SRC  latched, not-yet-granted requests.
REQ-009 event_count  out  CNT_W  accepted wake-up edges, all sources.
REQ-010 timeout_count  out  8  grants ended by timeout.
REQ-011 lost_count  out  8  edges arriving on an already-pending source.

Function
REQ-012 Each wake_up bit SHALL pass a 3-flop shift register; a rising edge is detected when the two oldest stages equal 01.
REQ-013 Edge on wake_up sampled at clki edge k SHALL set pending[i] at edge k+2.
REQ-014 Accepted edge (pending[i]=0 or cleared that cycle) SHALL increment event_count by 1, wrapping at 2^CNT_W.
REQ-015 Edge on source i with pending[i]=1 and not cleared that cycle SHALL increment lost_count, saturating at 255; pending unchanged.
REQ-016 FSM states SHALL be IDLE, GRANT, GAP.
REQ-017 IDLE -> GRANT when any pending bit is set; winner chosen round-robin, search starting at rr_ptr, upward, wrapping.
REQ-018 On IDLE -> GRANT: pending[winner] cleared, grant_id <= winner, WU_valid <= 1, tim_count <= 0, rr_ptr <= winner+1 mod N_SRC.
REQ-019 In GRANT, tim_count SHALL increment once per cycle.
REQ-020 GRANT -> GAP when WU_serviced=1, or tim_count = TIMEOUT-1 (timeout); WU_valid <= 0 on that transition.
REQ-021 Timeout exit SHALL increment timeout_count, saturating at 255; WU_serviced=1 in the same cycle takes priority (no timeout counted).
REQ-022 GAP SHALL last exactly one cycle and return to IDLE; WU_valid=0 during GAP.
REQ-023 Latency: pending set at edge n in IDLE -> WU_valid=1 after edge n+1.
REQ-024 New edge on the granted source during GRANT SHALL set pending again (re-request), counted as accepted.
REQ-025 WU_serviced while not in GRANT SHALL be ignored.
REQ-026 Simultaneous pending bits SHALL each be granted in turn; no source waits more than N_SRC-1 other grants.
REQ-027 grant_id SHALL hold its last value outside GRANT.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: state IDLE, WU_valid 0, grant_id 0, pending 0, rr_ptr 0, tim_count 0, all counters 0, synchronizer flops 0.
REQ-029 Reset mid-GRANT SHALL drop the grant with no timeout counted; edges in flight are lost.
REQ-030 Release of rst_n SHALL be synchronized externally; no wake_up edge is detected in the first 2 cycles after release.

Structure
REQ-031 Package wakeup_pkg SHALL hold N_SRC/TIMEOUT/CNT_W defaults and the FSM state enum.
REQ-032 Sub-module wakeup_sync (3-flop synchronizer plus rising-edge pulse) SHALL be instantiated once per source.
REQ-033 Arbitration, FSM, timer and counters SHALL reside in wakeup_arbiter.

Verification
REQ-034 Single pulse on wake_up[2], WU_serviced at 10 cycles after WU_valid -> grant_id=2, WU_valid high 10 cycles, event_count=1, timeout_count=0.
REQ-035 Pulse on wake_up[1], WU_serviced never asserted -> WU_valid high exactly 30000 cycles, timeout_count=1.
REQ-036 Pulses on sources 0,1,3 in the same cycle, each serviced after 5 cycles -> grants in order 0,1,3 with one GAP cycle between.
REQ-037 Two pulses on source 0 before its grant -> event_count=1, lost_count=1, one grant only.
REQ-038 WU_serviced=1 on the cycle tim_count=TIMEOUT-1 -> normal exit, timeout_count unchanged.
REQ-039 rst_n low for 1 cycle mid-GRANT -> WU_valid=0 immediately, all counters 0, next pulse is granted normally.

Source files
------------

// File: rtl/wakeup_pkg.sv
// Shared defaults and FSM encoding for the wake-up arbiter.
package wakeup_pkg;

  localparam int N_SRC_DEF   = 4;
  localparam int TIMEOUT_DEF = 30000;  // 300 us at 100 MHz
  localparam int CNT_W_DEF   = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } wu_state_e;

endpackage

// File: rtl/wakeup_sync.sv
// 3-flop synchronizer for one asynchronous wake-up line plus rising-edge pulse.
module wakeup_sync (
  input  logic clki,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  // sh[0] is the newest sample, sh[2] the oldest
  logic [2:0] sh;

  // shift the raw line through the synchronizer chain
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) sh <= '0;
    else        sh <= {sh[1:0], async_in};
  end

  // edge when the two oldest stages read 0 then 1
  assign rise = (sh[2:1] == 2'b01);

endmodule

// File: rtl/wakeup_arbiter.sv
// Round-robin arbiter for wake-up sources with a bounded service window.
module wakeup_arbiter
  import wakeup_pkg::*;
#(
  parameter int N_SRC   = N_SRC_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                     clki,
  input  logic                     rst_n,
  input  logic [N_SRC-1:0]         wake_up,
  input  logic                     WU_serviced,
  output logic                     WU_valid,
  output logic [$clog2(N_SRC)-1:0] grant_id,
  output logic [N_SRC-1:0]         pending,
  output logic [CNT_W-1:0]         event_count,
  output logic [7:0]               timeout_count,
  output logic [7:0]               lost_count
);

  localparam int ID_W  = $clog2(N_SRC);
  // one extra count of headroom so the increment on the exit cycle never wraps
  localparam int TIM_W = $clog2(TIMEOUT + 1);

  wu_state_e        state, state_nxt;
  logic [N_SRC-1:0] rise, clr, acc, lost;
  logic [ID_W-1:0]  rr_ptr, win;
  logic [TIM_W-1:0] tim_count;
  logic             found, do_grant, do_exit, do_tmo;
  logic [7:0]       lost_nxt;
  int               lost_sum;

  wakeup_sync u_sync [N_SRC-1:0] (
    .clki     (clki),
    .rst_n    (rst_n),
    .async_in (wake_up),
    .rise     (rise)
  );

  // round-robin search: first pending source at or above rr_ptr, wrapping
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int off = 0; off < N_SRC; off++) begin
      if (!found && pending[(int'(rr_ptr) + off) % N_SRC]) begin
        found = 1'b1;
        win   = ID_W'((int'(rr_ptr) + off) % N_SRC);
      end
    end
  end

  // next state and the control strobes for this cycle
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_exit   = 1'b0;
    do_tmo    = 1'b0;
    case (state)
      IDLE: if (found) begin
        do_grant  = 1'b1;
        state_nxt = GRANT;
      end
      GRANT: if (WU_serviced) begin
        // service completion wins over a coincident timeout
        do_exit   = 1'b1;
        state_nxt = GAP;
      end else if (tim_count == TIM_W'(TIMEOUT - 1)) begin
        do_exit   = 1'b1;
        do_tmo    = 1'b1;
        state_nxt = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // a source cleared by this grant can accept a new edge in the same cycle
  assign clr  = do_grant ? (N_SRC'(1) << win) : '0;
  assign acc  = rise & (~pending | clr);
  assign lost = rise & pending & ~clr;

  // saturating lost-edge total
  always_comb begin
    lost_sum = int'(lost_count) + $countones(lost);
    lost_nxt = (lost_sum > 255) ? 8'hFF : 8'(lost_sum);
  end

  // state register
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // grant bookkeeping, service timer, pending mask and event counters
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      WU_valid      <= 1'b0;
      grant_id      <= '0;
      pending       <= '0;
      rr_ptr        <= '0;
      tim_count     <= '0;
      event_count   <= '0;
      timeout_count <= '0;
      lost_count    <= '0;
    end else begin
      pending     <= (pending & ~clr) | acc;
      event_count <= event_count + CNT_W'($countones(acc));
      lost_count  <= lost_nxt;
      if (do_grant) begin
        grant_id  <= win;
        WU_valid  <= 1'b1;
        tim_count <= '0;
        rr_ptr    <= (int'(win) == N_SRC - 1) ? '0 : win + 1'b1;
      end else if (state == GRANT) begin
        tim_count <= tim_count + 1'b1;
      end
      if (do_exit) WU_valid <= 1'b0;
      if (do_tmo && timeout_count != 8'hFF) timeout_count <= timeout_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_wakeup_arbiter.sv
// Bench for wakeup_arbiter: directed scenarios plus random traffic against a
// cycle-stepped behavioural model.
module tb_wakeup_arbiter;

  localparam int N  = 4;
  localparam int TO = 30000;
  localparam int CW = 20;

  logic          clki;
  logic          rst_n = 1'b0;
  logic [N-1:0]  wake_up = '0;
  logic          WU_serviced = 1'b0;
  logic          WU_valid;
  logic [1:0]    grant_id;
  logic [N-1:0]  pending;
  logic [CW-1:0] event_count;
  logic [7:0]    timeout_count, lost_count;

  wakeup_arbiter #(.N_SRC(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clki          (clki),
    .rst_n         (rst_n),
    .wake_up       (wake_up),
    .WU_serviced   (WU_serviced),
    .WU_valid      (WU_valid),
    .grant_id      (grant_id),
    .pending       (pending),
    .event_count   (event_count),
    .timeout_count (timeout_count),
    .lost_count    (lost_count)
  );

  initial begin
    clki = 1'b0;
    forever #5 clki = ~clki;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // h0/h1/h2: wake_up as sampled 1/2/3 clock edges ago
  logic [N-1:0] h0, h1, h2, m_pend;
  int  m_phase;  // 0 waiting for work, 1 serving a grant, 2 gap after a grant
  int  m_gid, m_ptr, m_age, m_evt, m_tmo, m_lost;
  bit  m_vld;

  task automatic model_reset();
    h0 = '0; h1 = '0; h2 = '0; m_pend = '0;
    m_phase = 0; m_gid = 0; m_ptr = 0; m_age = 0;
    m_evt = 0; m_tmo = 0; m_lost = 0; m_vld = 1'b0;
  endtask

  task automatic model_tick();
    logic [N-1:0] rise, clr;
    bit got;
    int w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    // an edge seen at sample k lands in pending two edges later
    rise = h1 & ~h2;
    h2 = h1; h1 = h0; h0 = wake_up;
    clr = '0;
    case (m_phase)
      0: if (m_pend != 0) begin
        got = 1'b0;
        w = 0;
        for (int off = 0; off < N; off++)
          if (!got && m_pend[(m_ptr + off) % N]) begin
            got = 1'b1;
            w = (m_ptr + off) % N;
          end
        clr[w] = 1'b1;
        m_gid = w; m_vld = 1'b1; m_age = 0; m_ptr = (w + 1) % N; m_phase = 1;
      end
      1: begin
        if (WU_serviced) begin
          m_phase = 2; m_vld = 1'b0;
        end else if (m_age == TO - 1) begin
          m_phase = 2; m_vld = 1'b0;
          if (m_tmo < 255) m_tmo++;
        end
        m_age++;
      end
      default: m_phase = 0;
    endcase
    for (int i = 0; i < N; i++)
      if (rise[i]) begin
        if (!m_pend[i] || clr[i]) begin
          m_evt = (m_evt + 1) % (1 << CW);
          clr[i] = 1'b0;
          m_pend[i] = 1'b1;
        end else if (m_lost < 255) m_lost++;
      end
    m_pend = m_pend & ~clr;
  endtask

  task automatic cmp_all();
    chk("vld",  WU_valid,      m_vld);
    chk("gid",  grant_id,      m_gid);
    chk("pend", pending,       m_pend);
    chk("evt",  event_count,   m_evt);
    chk("tmo",  timeout_count, m_tmo);
    chk("lost", lost_count,    m_lost);
  endtask

  // one clock: model follows the inputs sampled at the edge, compare 1 ns later
  task automatic step();
    @(posedge clki);
    model_tick();
    #1;
    cmp_all();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst_n = 1'b0; wake_up = '0; WU_serviced = 1'b0;
    model_reset();
    #1;
    chk("rst_vld",  WU_valid,      0);
    chk("rst_evt",  event_count,   0);
    chk("rst_tmo",  timeout_count, 0);
    chk("rst_lost", lost_count,    0);
    chk("rst_pend", pending,       0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic pulse(input int src);
    wake_up[src] = 1'b1;
    step();
    wake_up[src] = 1'b0;
  endtask

  task automatic wait_vld(input int bound, output int n);
    n = 0;
    while (!WU_valid && n < bound) begin
      step();
      n++;
    end
    chk("wait_vld", WU_valid, 1);
  endtask

  // cycles the grant stays up; WU_serviced is sampled on edge svc_at after
  // the grant edge (0 means never serviced)
  task automatic hold_grant(input int svc_at, input int bound, output int n);
    n = 0;
    while (WU_valid && n < bound) begin
      n++;
      WU_serviced = (n == svc_at);
      step();
    end
    WU_serviced = 1'b0;
  endtask

  int n, ng;
  int exp_ord[3] = '{0, 1, 3};

  initial begin
    do_reset();
    repeat (3) step();

    // single serviced request on source 2
    pulse(2);
    wait_vld(10, n);
    chk("t1_gid", grant_id, 2);
    hold_grant(10, 100, n);
    chk("t1_len", n, 10);
    chk("t1_evt", event_count, 1);
    chk("t1_tmo", timeout_count, 0);
    repeat (4) step();

    // unserviced request on source 1 runs the full window
    pulse(1);
    wait_vld(10, n);
    chk("t2_gid", grant_id, 1);
    hold_grant(0, TO + 100, n);
    chk("t2_len", n, TO);
    chk("t2_tmo", timeout_count, 1);

    // three simultaneous requests from a fresh round-robin pointer
    do_reset();
    repeat (3) step();
    wake_up = 4'b1011;
    step();
    wake_up = '0;
    for (int g = 0; g < 3; g++) begin
      wait_vld(10, n);
      // low time between grants: the GAP cycle plus the IDLE cycle that grants
      if (g > 0) chk("t3_gap", n, 2);
      chk("t3_gid", grant_id, exp_ord[g]);
      hold_grant(5, 100, n);
      chk("t3_len", n, 5);
    end

    // source 0 pulses twice while source 3 holds the grant
    do_reset();
    repeat (3) step();
    pulse(3);
    wait_vld(10, n);
    chk("t4_gid3", grant_id, 3);
    pulse(0);
    repeat (3) step();
    pulse(0);
    repeat (3) step();
    chk("t4_pend", pending, 4'b0001);
    chk("t4_lost", lost_count, 1);
    chk("t4_evt", event_count, 2);  // one for source 3, one for source 0
    hold_grant(1, 100, n);
    wait_vld(10, n);
    chk("t4_gid0", grant_id, 0);
    hold_grant(3, 100, n);
    ng = 0;
    repeat (20) begin
      step();
      if (WU_valid) ng++;
    end
    chk("t4_regrant", ng, 0);

    // service arriving on the last cycle of the window is a normal exit
    do_reset();
    repeat (3) step();
    pulse(2);
    wait_vld(10, n);
    hold_grant(TO, TO + 100, n);
    chk("t5_len", n, TO);
    chk("t5_tmo", timeout_count, 0);

    // reset in the middle of a grant, then a fresh request
    pulse(1);
    wait_vld(10, n);
    repeat (4) step();
    do_reset();
    repeat (3) step();
    pulse(1);
    wait_vld(10, n);
    chk("t6_gid", grant_id, 1);
    chk("t6_evt", event_count, 1);
    hold_grant(2, 100, n);

    // random traffic with one reset in the middle
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) wake_up[i] = ($urandom_range(0, 15) == 0);
      WU_serviced = ($urandom_range(0, 3) == 0);
      if (c == 2000) do_reset();
      else step();
    end
    wake_up = '0;
    WU_serviced = 1'b0;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
